seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Iterative shift-add multiplier for the RV32M multiply group (MUL, MULH, MULHSU, MULHU). It sits in the EX stage beside the ALU. It receives rs1/rs2 from the ID/EX register, holds `busy` high to stall the pipeline, and delivers a 32-bit result to the EX/MEM writeback mux. Each iteration's partial-sum addition runs through the team's RCA adder (N = XLEN), so the block consumes the adder's XLEN+1-bit sum, including its carry-out.

## Interface
- XLEN, 32, operand and result width
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  request a multiply; honoured only when `busy`=0
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; bit 2 ignored
- rs1  input  XLEN  multiplicand; signed for MULH/MULHSU
- rs2  input  XLEN  multiplier; signed for MULH only
- busy  output  1  operation in progress; stall request
- done  output  1  one-cycle pulse; `result` is valid
- result  output  XLEN  low word (MUL) or high word (MULH*) of the 2·XLEN product

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1:
  - latch funct3;
  - convert rs1/rs2 to magnitudes according to signedness;
  - record neg = sign(rs1_eff) XOR sign(rs2_eff);
  - clear acc_hi; load acc_lo with |rs2|; clear count; go to CALC.
- CALC, each cycle:
  - if acc_lo[0]=1, sum = RCA(acc_hi, |rs1|), else sum = {1'b0, acc_hi};
  - {acc_hi, acc_lo} <= {sum, acc_lo[XLEN-1:1]}, i.e. a 2·XLEN+1-bit value shifted right by one;
  - count increments; after XLEN iterations go to FIX.
- FIX: if neg, the 2·XLEN product is replaced by its two's complement (invert, +1). Go to DONE.
- DONE: done=1 and `result` is driven from the product according to funct3. Go to IDLE.
- Widths:
  - the adder carry-out is never discarded; it becomes the MSB of acc_hi after the shift;
  - the unsigned product always fits in 2·XLEN bits.
- `result` holds its value until the next DONE. `done` is 0 in all other states.
- `busy` = 1 in CALC, FIX and DONE; `busy` = 0 in IDLE.
- `start` while `busy`=1 is ignored. Operands are not re-sampled.
- Reset mid-operation aborts the operation:
  - the next edge returns the block to IDLE;
  - busy=0, done=0, result=0, count=0.
- Reset values: busy 0, done 0, result 0, state IDLE.

## Timing
- Let start be sampled at edge E0 (IDLE).
- CALC occupies the cycles following edges E0..E(XLEN-1).
- FIX occupies the cycle following E(XLEN).
- DONE occupies the cycle following E(XLEN+1). `done` and `result` are visible there.
- Latency: XLEN+2 cycles from start to done, i.e. 34 for XLEN=32.
- `busy` rises the cycle after E0 and falls the cycle after DONE.
- Back-to-back: start may be asserted during the DONE cycle but is not accepted. It is sampled in the following IDLE cycle, so the minimum issue interval is XLEN+3.
- The upstream stage holds rs1/rs2/funct3 stable only during the start cycle.

## Configuration
- SEQ_MUL_EARLY_EXIT_EN:
  - Defined: CALC exits to FIX as soon as the unconsumed multiplier bits are all zero. Before FIX, acc_hi/acc_lo are realigned by shifting right by the remaining XLEN-count positions in one step. Latency is then (index of the highest set bit of |rs2|)+1+2 cycles, with a minimum of 3 when rs2=0.
  - Undefined: CALC always runs a fixed XLEN iterations, giving latency XLEN+2.
  - Results are identical in both builds.

## Structure
- Shared package/header holds:
  - the funct3 encodings (F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU);
  - the state encoding (2-bit: IDLE=0, CALC=1, FIX=2, DONE=3);
  - the counter width, $clog2(XLEN)+1.
- Sub-module: one instance of RCA with N=XLEN for the per-iteration add. The FIX negation uses a separate 2·XLEN increment inside this block.

## Test plan
- MUL, rs1=7, rs2=6 -> result 0x0000002A; done high exactly 34 cycles after start (fixed-latency build).
- MULH, rs1=0x80000000, rs2=0x80000000 -> result 0x40000000. MUL on the same operands -> 0x00000000.
- MULHSU, rs1=0xFFFFFFFF (−1), rs2=0xFFFFFFFF (unsigned) -> result 0xFFFFFFFF. MULHU on the same operands -> 0xFFFFFFFE.
- start pulsed again at cycles 5 and 20 of an active MUL 3×5 -> ignored; a single done; result 0x0000000F.
- rst asserted at CALC cycle 10 -> next cycle busy=0, done=0, result=0. A new MUL 2×3 then yields 0x00000006 after full latency.
- SEQ_MUL_EARLY_EXIT_EN defined, MUL rs1=0x12345678, rs2=1 -> result 0x12345678; done 3 cycles after start.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
// Optional build macro: SEQ_MUL_EARLY_EXIT_EN (see seq_multiplier.sv).
package seq_multiplier_pkg;

    localparam int XLEN  = 32;
    localparam int PW    = 2 * XLEN;
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // funct3 bit 2 does not select a multiply variant
    function automatic logic [2:0] f3_norm(input logic [2:0] f3);
        return f3 & 3'b011;
    endfunction

    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3_norm(f3) == F3_MULH) || (f3_norm(f3) == F3_MULHSU);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return f3_norm(f3) == F3_MULH;
    endfunction

    function automatic logic low_word(input logic [2:0] f3);
        return f3_norm(f3) == F3_MUL;
    endfunction

endpackage

// File: rtl/seq_multiplier_rca.sv
// Ripple-carry adder, N-bit operands, N+1-bit sum including carry-out.
// Used once per multiplier iteration for the partial-sum add.
module seq_multiplier_rca #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N:0]   sum_o
);

    logic [N:0]   c;
    logic [N-1:0] s;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign sum_o = {c[N], s};

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU in EX.
// Build macro SEQ_MUL_EARLY_EXIT_EN: leave CALC once no multiplier bits remain.
module seq_multiplier
    import seq_multiplier_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] ONE_W  = XLEN'(1);
    localparam logic [XLEN-1:0] ONES_W = '1;
    localparam logic [PW-1:0]   ONE_P  = PW'(1);

    state_e state_q, state_d;

    logic [XLEN-1:0]  acc_hi_q, acc_hi_d;
    logic [XLEN-1:0]  acc_lo_q, acc_lo_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [2:0]       f3_q, f3_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic [XLEN-1:0]  addend;
    logic [XLEN:0]    sum;
    logic [CNT_W-1:0] count_p1;
    logic [CNT_W-1:0] shamt;
    logic             calc_exit;
    logic [PW-1:0]    step;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_fix;
    logic             s1, s2;
    logic [XLEN-1:0]  mag1, mag2;

    assign addend   = acc_lo_q[0] ? mcand_q : '0;
    assign count_p1 = count_q + CNT_W'(1);

    seq_multiplier_rca #(
        .N (XLEN)
    ) u_rca (
        .a_i   (acc_hi_q),
        .b_i   (addend),
        .sum_o (sum)
    );

`ifdef SEQ_MUL_EARLY_EXIT_EN
    // exit once unconsumed multiplier bits are zero; realign in one shift
    always_comb begin
        calc_exit = (count_q == CNT_W'(XLEN - 1)) ||
                    (((acc_lo_q >> 1) & (ONES_W >> count_p1)) == '0);
        shamt     = calc_exit ? (CNT_W'(XLEN) - count_q) : CNT_W'(1);
    end
`else
    // fixed XLEN iterations, one bit per cycle
    always_comb begin
        calc_exit = (count_q == CNT_W'(XLEN - 1));
        shamt     = CNT_W'(1);
    end
`endif

    assign step     = PW'({sum, acc_lo_q} >> shamt);
    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_q ? (~prod + ONE_P) : prod;

    assign s1   = rs1_signed(funct3);
    assign s2   = rs2_signed(funct3);
    assign mag1 = (s1 && rs1[XLEN-1]) ? (~rs1 + ONE_W) : rs1;
    assign mag2 = (s2 && rs2[XLEN-1]) ? (~rs2 + ONE_W) : rs2;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = CALC;
            CALC: if (calc_exit) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        result = result_q;
    end

    // datapath next-state
    always_comb begin
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        count_d  = count_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    f3_d     = funct3;
                    mcand_d  = mag1;
                    neg_d    = (s1 & rs1[XLEN-1]) ^ (s2 & rs2[XLEN-1]);
                    acc_hi_d = '0;
                    acc_lo_d = mag2;
                    count_d  = '0;
                end
            end
            CALC: begin
                acc_hi_d = step[PW-1:XLEN];
                acc_lo_d = step[XLEN-1:0];
                count_d  = count_p1;
            end
            FIX: begin
                result_d = low_word(f3_q) ? prod_fix[XLEN-1:0]
                                          : prod_fix[PW-1:XLEN];
            end
            default: ;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier.
// Reference product is computed with 64-bit arithmetic on extended operands.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int dones  = 0;

    logic [31:0] exp_q[$];

    seq_multiplier dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic        sa, sb;
        sa = (f3[1:0] == 2'b01) || (f3[1:0] == 2'b10);
        sb = (f3[1:0] == 2'b01);
        ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int model_lat(input logic [2:0] f3,
                                     input logic [31:0] b);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        logic [31:0] m;
        int          hi;
        m  = (f3[1:0] == 2'b01 && b[31]) ? (~b + 32'd1) : b;
        hi = 0;
        for (int i = 0; i < 32; i++) if (m[i]) hi = i;
        return hi + 3;
`else
        return (f3 == f3) ? 34 : 34;
`endif
    endfunction

    // compare every done pulse against the scoreboard head
    always @(negedge clk) begin
        if (done) begin
            dones++;
            if (exp_q.size() == 0) chk("spurious_done", 1, 0);
            else chk("result", result, exp_q.pop_front());
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        int n;
        int d0;
        @(negedge clk);
        d0     = dones;
        start  = 1'b1;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        exp_q.push_back(model(f3, a, b));
        @(posedge clk); #1;
        start = 1'b0;
        rs1   = $urandom;
        rs2   = $urandom;
        chk("busy_rise", busy, 1);
        n = 1;
        forever begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (n > 100) begin
                chk("timeout", 0, 1);
                break;
            end
            if (poke && (n == 5 || n == 20)) begin
                start  = 1'b1;
                funct3 = 3'($urandom);
                rs1    = $urandom;
                rs2    = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("latency", n, model_lat(f3, b));
        @(posedge clk); #1;
        chk("busy_fall", busy, 0);
        chk("done_count", dones - d0, 1);
    endtask

    initial begin
        logic [31:0] edge_v[6];
        edge_v = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                   32'h7FFFFFFF, 32'h12345678};
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        rs1    = '0;
        rs2    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        rst = 1'b0;

        run_op(3'b000, 32'd7, 32'd6, 0);
        run_op(3'b001, 32'h80000000, 32'h80000000, 0);
        run_op(3'b000, 32'h80000000, 32'h80000000, 0);
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(3'b000, 32'h12345678, 32'd1, 0);
        run_op(3'b000, 32'd3, 32'd5, 1);

        // abort mid-calculation
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b000;
        rs1    = 32'h0BADF00D;
        rs2    = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_busy_pre", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        rst = 1'b0;
        run_op(3'b000, 32'd2, 32'd3, 0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            a = (i % 3 == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            b = (i % 4 == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            if (i % 5 == 1) b = b >> $urandom_range(0, 31);
            run_op(3'($urandom), a, b, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
